// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // MIPS HI/LO arithmetic operations; bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Control states of the unit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration datapath: shift-add multiply on a 2*WIDTH accumulator and
// restoring divide producing one quotient bit per step. Operands arrive
// already made non-negative; sign correction happens in the top.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               rest_zero
);

  // Divide: acc holds {remainder, dividend/quotient}; mplier holds the divisor.
  // Multiply: acc holds the partial product; mcand shifts left, mplier shifts right.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  logic [WIDTH:0]     div_shifted;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_next;

  // One restoring-divide step and one shift-add step, computed in parallel.
  always_comb begin
    div_shifted = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff    = div_shifted - {1'b0, mplier_q};
    div_next    = {(div_diff[WIDTH] ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    mul_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Operand load and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      acc_q    <= is_div ? {{WIDTH{1'b0}}, a} : '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (step) begin
      if (is_div) begin
        acc_q <= div_next;
      end else begin
        acc_q    <= mul_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  assign acc       = acc_q;
  // No multiplier bits remain beyond the one consumed this cycle.
  assign rest_zero = (mplier_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit writing HI/LO, with pipeline stall
// request and flush abort. Optional build macro MUL_EARLY_TERM_EN lets a
// multiply leave RUN once the remaining multiplier bits are all zero.
//
// Handshake: start is accepted only in IDLE without flush. While busy, a new
// start or an MFHI/MFLO (hilo_rd) raises stall_req; the requester holds its
// request and re-presents it once busy drops. done pulses for one cycle after
// hi/lo are written; both registers are always written together.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               res_neg_q;
  logic               rem_neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               load, step, write, run_last;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc;
  logic               rest_zero;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Magnitudes and sign flags of the incoming operands.
  always_comb begin
    a_neg = op_is_signed(op_e'(op)) & opA[WIDTH-1];
    b_neg = op_is_signed(op_e'(op)) & opB[WIDTH-1];
    abs_a = a_neg ? -opA : opA;
    abs_b = b_neg ? -opB : opB;
  end

`ifdef MUL_EARLY_TERM_EN
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1)) | (~is_div_q & rest_zero);
`else
  logic unused_rest_zero;
  assign unused_rest_zero = rest_zero;
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (run_last) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        write   = !flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Iteration counter and latched operation attributes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (load) begin
      cnt_q     <= '0;
      is_div_q  <= op_is_div(op_e'(op));
      // A zero divisor yields an all-ones quotient regardless of signs.
      res_neg_q <= op_is_div(op_e'(op)) ? ((a_neg ^ b_neg) & (opB != '0)) : (a_neg ^ b_neg);
      rem_neg_q <= a_neg;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .is_div    (load ? op_is_div(op_e'(op)) : is_div_q),
    .a         (abs_a),
    .b         (abs_b),
    .acc       (acc),
    .rest_zero (rest_zero)
  );

  // Sign correction of the magnitude result.
  always_comb begin
    mul_res = res_neg_q ? -acc : acc;
    if (is_div_q) begin
      fix_lo = res_neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = mul_res[WIDTH-1:0];
      fix_hi = mul_res[2*WIDTH-1:WIDTH];
    end
  end

  // Architectural HI/LO update and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= write;
      if (write) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (hilo_rd | start);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
